// File: rtl/factorial_pkg.sv
// factorial_pkg: shared widths and FSM encoding
// for the iterative factorial engine.
package factorial_pkg;
   localparam int NUM_W = 4;
   localparam int RES_W = 16;
   localparam int REQ_N = 2;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } fact_state_t;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant with a
// registered priority pointer that moves on accept.
module rr_arbiter2
   import factorial_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] grant,
   output logic       grant_id
);
   logic prio_q;
   logic prio_d;

   always_comb begin
      grant = 2'b00;
      unique case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = prio_q ? 2'b10 : 2'b01;
         default: grant = 2'b00;
      endcase
      grant_id = grant[1];
      prio_d   = prio_q;
      // Next priority goes to whoever lost this round.
      if (accept) prio_d = ~grant_id;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) prio_q <= 1'b0;
      else        prio_q <= prio_d;
   end
endmodule

// File: rtl/factorial_sequencer.sv
// factorial_sequencer: shared n! engine, one multiply
// per clock, arbitrated between two requesters.
module factorial_sequencer
   import factorial_pkg::*;
#(
   parameter int NUM_W = factorial_pkg::NUM_W,
   parameter int RES_W = factorial_pkg::RES_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       req_valid,
   input  logic [NUM_W-1:0] req_num0,
   input  logic [NUM_W-1:0] req_num1,
   output logic [1:0]       req_ready,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic             resp_id,
   output logic [RES_W-1:0] resp_res,
   output logic             resp_ovf,
   output logic             busy
);
   fact_state_t      state_q, state_d;
   logic [NUM_W-1:0] n_q, n_d;
   logic             id_q, id_d;
   logic [RES_W-1:0] acc_q, acc_d;
   logic [NUM_W:0]   cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             rv_q, rv_d;
   logic             rid_q, rid_d;
   logic [RES_W-1:0] rres_q, rres_d;
   logic             rovf_q, rovf_d;

   logic [RES_W+NUM_W:0] prod;
   logic [1:0]           arb_req;
   logic                 grant_id;
   logic                 accept;

   // Gated by rst_n so req_ready reads 0 while held in reset.
   assign arb_req = (state_q == IDLE && rst_n) ? req_valid : 2'b00;
   assign accept  = |(req_valid & req_ready);

   rr_arbiter2 u_arb (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (arb_req),
      .accept   (accept),
      .grant    (req_ready),
      .grant_id (grant_id)
   );

   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      id_d    = id_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      rv_d    = rv_q;
      rid_d   = rid_q;
      rres_d  = rres_q;
      rovf_d  = rovf_q;
      prod    = {{(NUM_W+1){1'b0}}, acc_q} * {{RES_W{1'b0}}, cnt_q};
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               n_d     = grant_id ? req_num1 : req_num0;
               id_d    = grant_id;
               acc_d   = RES_W'(1);
               cnt_d   = (NUM_W+1)'(1);
               ovf_d   = 1'b0;
               state_d = CALC;
            end
         end
         CALC: begin
            acc_d = prod[RES_W-1:0];
            ovf_d = ovf_q | (|prod[RES_W+NUM_W:RES_W]);
            cnt_d = cnt_q + 1'b1;
            if (cnt_q >= {1'b0, n_q}) begin
               state_d = DONE;
               rv_d    = 1'b1;
               rres_d  = acc_d;
               rovf_d  = ovf_d;
               rid_d   = id_q;
            end
         end
         DONE: begin
            if (resp_ready) begin
               state_d = IDLE;
               rv_d    = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         n_q     <= '0;
         id_q    <= 1'b0;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         rv_q    <= 1'b0;
         rid_q   <= 1'b0;
         rres_q  <= '0;
         rovf_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         id_q    <= id_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         rv_q    <= rv_d;
         rid_q   <= rid_d;
         rres_q  <= rres_d;
         rovf_q  <= rovf_d;
      end
   end

   assign resp_valid = rv_q;
   assign resp_id    = rid_q;
   assign resp_res   = rres_q;
   assign resp_ovf   = rovf_q;
   assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_factorial_sequencer.sv
// tb_factorial_sequencer: directed vectors and
// multi-cycle sequences for factorial_sequencer.
module tb_factorial_sequencer;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  req_valid = 2'b00;
   logic [3:0]  req_num0 = '0;
   logic [3:0]  req_num1 = '0;
   logic [1:0]  req_ready;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic        resp_id;
   logic [15:0] resp_res;
   logic        resp_ovf;
   logic        busy;

   int checks = 0;
   int errors = 0;

   factorial_sequencer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_num0   (req_num0),
      .req_num1   (req_num1),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_id    (resp_id),
      .resp_res   (resp_res),
      .resp_ovf   (resp_ovf),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          id;
      logic [3:0]  n;
      logic [15:0] res;
      logic        ovf;
      int          lat;
   } vec_t;

   vec_t vecs[8];

   function automatic logic [15:0] fact_mod(input logic [3:0] n);
      longint f = 1;
      for (int i = 2; i <= int'(n); i++) f = f * i;
      return f[15:0];
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input int id, input logic [3:0] n);
      bit ok = 0;
      if (id == 0) req_num0 = n;
      else         req_num1 = n;
      req_valid[id] = 1'b1;
      #1;
      for (int k = 0; k < 30; k++) begin
         if (req_ready[id]) begin
            ok = 1;
            break;
         end
         tick();
      end
      if (ok) tick();
      req_valid[id] = 1'b0;
      chk($sformatf("accept id%0d n%0d", id, n), 32'(ok), 32'd1);
   endtask

   task automatic wait_resp(output int lat);
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (resp_valid) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic consume();
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      chk("resp_valid after handshake", 32'(resp_valid), 32'd0);
      chk("busy after handshake", 32'(busy), 32'd0);
   endtask

   task automatic check_reset_outs(input string tag);
      chk({tag, " req_ready"}, 32'(req_ready), 32'd0);
      chk({tag, " resp_valid"}, 32'(resp_valid), 32'd0);
      chk({tag, " resp_id"}, 32'(resp_id), 32'd0);
      chk({tag, " resp_res"}, 32'(resp_res), 32'd0);
      chk({tag, " resp_ovf"}, 32'(resp_ovf), 32'd0);
      chk({tag, " busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      vecs[0] = '{0, 4'd0,  16'd1,     1'b0, 1};
      vecs[1] = '{0, 4'd1,  16'd1,     1'b0, 1};
      vecs[2] = '{1, 4'd8,  16'd40320, 1'b0, 8};
      vecs[3] = '{0, 4'd9,  16'd35200, 1'b1, 9};
      vecs[4] = '{1, 4'd15, 16'd22528, 1'b1, 15};
      vecs[5] = '{0, 4'd3,  16'd6,     1'b0, 3};
      vecs[6] = '{1, 4'd5,  16'd120,   1'b0, 5};
      vecs[7] = '{0, 4'd2,  16'd2,     1'b0, 2};

      // Reset defaults, with both requesters asserting valid.
      req_valid = 2'b11;
      tick();
      tick();
      check_reset_outs("por");
      req_valid = 2'b00;
      rst_n = 1'b1;
      tick();

      foreach (vecs[i]) begin
         issue(vecs[i].id, vecs[i].n);
         wait_resp(lat);
         chk($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].lat));
         chk($sformatf("v%0d res", i), 32'(resp_res), 32'(vecs[i].res));
         chk($sformatf("v%0d model", i), 32'(resp_res),
             32'(fact_mod(vecs[i].n)));
         chk($sformatf("v%0d ovf", i), 32'(resp_ovf), 32'(vecs[i].ovf));
         chk($sformatf("v%0d id", i), 32'(resp_id), 32'(vecs[i].id));
         consume();
      end

      // Back-pressure: response held while requester 1 waits.
      issue(0, 4'd4);
      wait_resp(lat);
      chk("bp latency", 32'(lat), 32'd4);
      req_num1 = 4'd2;
      req_valid[1] = 1'b1;
      #1;
      for (int k = 0; k < 5; k++) begin
         chk("bp resp_valid", 32'(resp_valid), 32'd1);
         chk("bp resp_res", 32'(resp_res), 32'd24);
         chk("bp resp_ovf", 32'(resp_ovf), 32'd0);
         chk("bp resp_id", 32'(resp_id), 32'd0);
         chk("bp req_ready", 32'(req_ready), 32'd0);
         tick();
      end
      resp_ready = 1'b1;
      tick();
      resp_ready = 1'b0;
      chk("bp released", 32'(resp_valid), 32'd0);
      chk("bp idle grant", 32'(req_ready), 32'b10);
      issue(1, 4'd2);
      wait_resp(lat);
      chk("bp next res", 32'(resp_res), 32'd2);
      chk("bp next id", 32'(resp_id), 32'd1);
      consume();

      // Reset mid-CALC for n = 7.
      issue(1, 4'd7);
      tick();
      tick();
      chk("mid busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check_reset_outs("mid");
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         tick();
         chk("no leftover", 32'(resp_valid), 32'd0);
      end
      issue(0, 4'd3);
      wait_resp(lat);
      chk("post-reset latency", 32'(lat), 32'd3);
      chk("post-reset res", 32'(resp_res), 32'd6);
      chk("post-reset id", 32'(resp_id), 32'd0);
      consume();

      // Arbitration from a fresh pointer with both requesters valid.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      req_num0 = 4'd1;
      req_num1 = 4'd1;
      req_valid = 2'b11;
      resp_ready = 1'b1;
      #1;
      for (int g = 0; g < 4; g++) begin
         bit found = 0;
         for (int k = 0; k < 20; k++) begin
            if (req_ready != 2'b00) begin
               found = 1;
               break;
            end
            tick();
         end
         chk($sformatf("arb%0d grant seen", g), 32'(found), 32'd1);
         chk($sformatf("arb%0d onehot", g), $countones(req_ready), 32'd1);
         chk($sformatf("arb%0d winner", g), 32'(req_ready),
             (g % 2 == 1) ? 32'b10 : 32'b01);
         tick();
         chk($sformatf("arb%0d busy", g), 32'(busy), 32'd1);
         for (int k = 0; k < 10; k++) begin
            if (!busy) break;
            chk($sformatf("arb%0d ready low", g), 32'(req_ready), 32'd0);
            if (resp_valid)
               chk($sformatf("arb%0d resp_id", g), 32'(resp_id),
                   32'(g % 2));
            tick();
         end
      end
      req_valid = 2'b00;
      resp_ready = 1'b0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule
